// File: rtl/rr_merge2_pkg.sv
// rr_merge2_pkg: shared widths, reset values and encodings for the rr_merge2 merger
package rr_merge2_pkg;
    localparam int W_DEF = 8;
    localparam int CW_DEF = 8;
    localparam logic LAST_RST = 1'b1;
    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;
endpackage

// File: rtl/rr_merge2_if.sv
// rr_merge2_if: two valid/ready input channels plus one output channel and the grant line
// D0/V0/R0, D1/V1/R1 : input channels (R* driven by the merger)
// Y/VY/RY           : output channel (RY driven by downstream)
// S1                : current grant/select, 0 = channel 0, 1 = channel 1
interface rr_merge2_if #(parameter int W = 8);
    logic [W-1:0] D0;
    logic         V0;
    logic         R0;
    logic [W-1:0] D1;
    logic         V1;
    logic         R1;
    logic [W-1:0] Y;
    logic         VY;
    logic         RY;
    logic         S1;
    modport master (output D0, V0, D1, V1, RY, input R0, R1, Y, VY, S1);
    modport slave (input D0, V0, D1, V1, RY, output R0, R1, Y, VY, S1);
endinterface

// File: rtl/rr_merge2_mux21.sv
// rr_merge2_mux21: one-bit 2-to-1 multiplexer slice
// s : select (0 = a, 1 = b); a, b : data inputs; y : selected bit
module rr_merge2_mux21 (
    input  logic s,
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = s ? b : a;
endmodule

// File: rtl/rr_merge2.sv
// rr_merge2: two-channel round-robin stream merger with a one-entry output register
// CLK, RST   : clock and asynchronous active-high reset
// bus        : input channels D0/V0/R0, D1/V1/R1, output Y/VY/RY, grant S1
// CNT0, CNT1 : wrapping counts of words accepted on each channel
module rr_merge2
    import rr_merge2_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    rr_merge2_if.slave    bus,
    output logic [CW-1:0] CNT0,
    output logic [CW-1:0] CNT1
);
    logic [0:0]   st;
    logic         last;
    logic         ld;
    logic [W-1:0] y_q;
    logic [W-1:0] mux_y;
    // Loading is allowed whenever the register is empty or being drained this cycle
    assign ld = (st == ST_EMPTY) | bus.RY;
    // Contested cycles alternate against the previous winner; uncontested go to whoever is valid
    assign bus.S1 = (bus.V0 & bus.V1) ? ~last : (bus.V1 ? SEL_CH1 : SEL_CH0);
    assign bus.R0 = ld & (bus.S1 == SEL_CH0) & bus.V0;
    assign bus.R1 = ld & (bus.S1 == SEL_CH1) & bus.V1;
    assign bus.Y = y_q;
    assign bus.VY = (st == ST_FULL);
    for (genvar i = 0; i < W; i++) begin : g_mux
        rr_merge2_mux21 u_mux (
            .s(bus.S1),
            .a(bus.D0[i]),
            .b(bus.D1[i]),
            .y(mux_y[i])
        );
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st <= ST_EMPTY;
            last <= LAST_RST;
            y_q <= '0;
            CNT0 <= '0;
            CNT1 <= '0;
        end else begin
            if (bus.R0 | bus.R1) begin
                y_q <= mux_y;
                st <= ST_FULL;
                last <= bus.S1;
            end else if (bus.RY) begin
                st <= ST_EMPTY;
            end
            if (bus.R0) CNT0 <= CNT0 + CW'(1);
            if (bus.R1) CNT1 <= CNT1 + CW'(1);
        end
    end
endmodule

// File: tb/tb_rr_merge2.sv
// tb_rr_merge2: directed self-checking bench for rr_merge2
module tb_rr_merge2;
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] CNT0;
    logic [7:0] CNT1;
    int         tests = 0;
    int         fails = 0;
    rr_merge2_if #(.W(8)) bus ();
    rr_merge2 #(.W(8), .CW(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .CNT0(CNT0),
        .CNT1(CNT1)
    );
    always #5 CLK = ~CLK;
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic do_reset();
        RST = 1'b1;
        #1;
        RST = 1'b0;
        #1;
    endtask
    task automatic test_reset();
        tests++; if (bus.Y !== 8'h00 || bus.VY !== 1'b0) begin fails++; $display("FAIL reset_init Y=%h VY=%b want 00/0", bus.Y, bus.VY); end
        tests++; if (CNT0 !== 8'h00 || CNT1 !== 8'h00) begin fails++; $display("FAIL reset_init_cnt %h/%h want 00/00", CNT0, CNT1); end
        @(negedge CLK);
        RST = 1'b0;
        bus.V0 = 1'b1; bus.D0 = 8'hA5; bus.RY = 1'b0;
        step();
        tests++; if (bus.Y !== 8'hA5 || bus.VY !== 1'b1 || CNT0 !== 8'h01) begin fails++; $display("FAIL preload Y=%h VY=%b CNT0=%h want a5/1/01", bus.Y, bus.VY, CNT0); end
        #2 RST = 1'b1;
        #1;
        tests++; if (bus.Y !== 8'h00 || bus.VY !== 1'b0 || CNT0 !== 8'h00 || CNT1 !== 8'h00) begin fails++; $display("FAIL async_reset Y=%h VY=%b CNT=%h/%h want 00/0/00/00", bus.Y, bus.VY, CNT0, CNT1); end
        #1 RST = 1'b0;
        bus.V0 = 1'b1; bus.V1 = 1'b1; bus.D0 = 8'h11; bus.D1 = 8'h22; bus.RY = 1'b1;
        #1;
        tests++; if (bus.S1 !== 1'b0 || bus.R0 !== 1'b1 || bus.R1 !== 1'b0) begin fails++; $display("FAIL first_grant S1=%b R0=%b R1=%b want 0/1/0", bus.S1, bus.R0, bus.R1); end
        step();
        tests++; if (bus.Y !== 8'h11 || bus.VY !== 1'b1) begin fails++; $display("FAIL first_word Y=%h VY=%b want 11/1", bus.Y, bus.VY); end
    endtask
    task automatic test_alternation();
        logic [7:0] exp;
        do_reset();
        bus.V0 = 1'b1; bus.V1 = 1'b1; bus.D0 = 8'h11; bus.D1 = 8'h22; bus.RY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 8'h11 : 8'h22;
            step();
            tests++; if (bus.Y !== exp || bus.VY !== 1'b1) begin fails++; $display("FAIL alternate[%0d] Y=%h VY=%b want %h/1", i, bus.Y, bus.VY, exp); end
        end
        tests++; if (CNT0 !== 8'd3 || CNT1 !== 8'd3) begin fails++; $display("FAIL alternate_cnt %0d/%0d want 3/3", CNT0, CNT1); end
    endtask
    task automatic test_backpressure();
        bus.RY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.R0 !== 1'b0 || bus.R1 !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d] R0=%b R1=%b want 0/0", i, bus.R0, bus.R1); end
            step();
            tests++; if (bus.Y !== 8'h22 || bus.VY !== 1'b1) begin fails++; $display("FAIL hold_data[%0d] Y=%h VY=%b want 22/1", i, bus.Y, bus.VY); end
        end
        bus.RY = 1'b1;
        #1;
        tests++; if (bus.R0 !== 1'b1 || bus.R1 !== 1'b0) begin fails++; $display("FAIL release_ready R0=%b R1=%b want 1/0", bus.R0, bus.R1); end
        step();
        tests++; if (bus.Y !== 8'h11 || bus.VY !== 1'b1 || CNT0 !== 8'd4) begin fails++; $display("FAIL release_word Y=%h VY=%b CNT0=%0d want 11/1/4", bus.Y, bus.VY, CNT0); end
    endtask
    task automatic test_single();
        logic [7:0] d;
        bus.V0 = 1'b0; bus.V1 = 1'b1; bus.RY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = 8'h30 + 8'(i);
            bus.D1 = d;
            #1;
            tests++; if (bus.S1 !== 1'b1 || bus.R1 !== 1'b1) begin fails++; $display("FAIL single_grant[%0d] S1=%b R1=%b want 1/1", i, bus.S1, bus.R1); end
            step();
            tests++; if (bus.Y !== d) begin fails++; $display("FAIL single_data[%0d] Y=%h want %h", i, bus.Y, d); end
        end
        bus.V0 = 1'b1; bus.D0 = 8'h77;
        #1;
        tests++; if (bus.S1 !== 1'b0) begin fails++; $display("FAIL after_single_grant S1=%b want 0", bus.S1); end
        step();
        tests++; if (bus.Y !== 8'h77) begin fails++; $display("FAIL after_single_data Y=%h want 77", bus.Y); end
    endtask
    task automatic test_wrap();
        do_reset();
        bus.V0 = 1'b1; bus.V1 = 1'b0; bus.RY = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.D0 = 8'(i);
            step();
            if (i == 254) begin
                tests++; if (CNT0 !== 8'hFF) begin fails++; $display("FAIL wrap_pre CNT0=%h want ff", CNT0); end
            end
        end
        tests++; if (CNT0 !== 8'h00 || CNT1 !== 8'h00) begin fails++; $display("FAIL wrap CNT0=%h CNT1=%h want 00/00", CNT0, CNT1); end
        tests++; if (bus.Y !== 8'hFF) begin fails++; $display("FAIL wrap_last_y Y=%h want ff", bus.Y); end
    endtask
    task automatic test_drain();
        do_reset();
        bus.V0 = 1'b1; bus.V1 = 1'b0; bus.D0 = 8'h5A; bus.RY = 1'b1;
        step();
        bus.V0 = 1'b0; bus.D0 = 8'h00;
        #1;
        tests++; if (bus.VY !== 1'b1 || bus.Y !== 8'h5A) begin fails++; $display("FAIL drain_loaded Y=%h VY=%b want 5a/1", bus.Y, bus.VY); end
        tests++; if (bus.S1 !== 1'b0 || bus.R0 !== 1'b0 || bus.R1 !== 1'b0) begin fails++; $display("FAIL idle_grant S1=%b R0=%b R1=%b want 0/0/0", bus.S1, bus.R0, bus.R1); end
        step();
        tests++; if (bus.VY !== 1'b0 || bus.Y !== 8'h5A) begin fails++; $display("FAIL drain_empty Y=%h VY=%b want 5a/0", bus.Y, bus.VY); end
        step();
        tests++; if (bus.VY !== 1'b0 || CNT0 !== 8'd1 || CNT1 !== 8'd0) begin fails++; $display("FAIL drain_idle VY=%b CNT=%0d/%0d want 0/1/0", bus.VY, CNT0, CNT1); end
    endtask
    initial begin
        RST = 1'b1;
        bus.V0 = 1'b0; bus.V1 = 1'b0; bus.D0 = 8'h00; bus.D1 = 8'h00; bus.RY = 1'b0;
        #1;
        test_reset();
        test_alternation();
        test_backpressure();
        test_single();
        test_wrap();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_merge2.md
Name: rr_merge2

Overview:
Two-channel round-robin stream merger with a one-entry output register.
- Arbitrates between two valid/ready input channels (D0 and D1) and forwards one word per accepted transfer to a single output channel.
- Sits directly upstream of the lab's bit-slice 2-1 multiplexer datapath: the arbiter drives the select line S1, and a W-wide bank of mux21 slices performs the data selection.
- Used in the hardware lab as the first sequential stage built on the mux.

Parameters:
W, 8, data width of each input channel and of the output.
CW, 8, width of the per-channel accepted-transfer counters.

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  reset, asynchronous, active-high
D0  input  W  channel 0 data
V0  input  1  channel 0 valid
R0  output  1  channel 0 ready (combinational)
D1  input  W  channel 1 data
V1  input  1  channel 1 valid
R1  output  1  channel 1 ready (combinational)
Y  output  W  output data (registered)
VY  output  1  output valid (registered)
RY  input  1  downstream ready
S1  output  1  current grant/select; 0 = channel 0, 1 = channel 1 (combinational); drives the mux21 bank
CNT0  output  CW  count of channel 0 words accepted (registered)
CNT1  output  CW  count of channel 1 words accepted (registered)

Behaviour:
- One clock (CLK); reset RST is asynchronous and active-high.
- On RST, regardless of CLK, asynchronously:
  - Y=0, VY=0, CNT0=0, CNT1=0.
  - Internal LAST=1, so channel 0 wins the first contest.
  - Any held word is discarded.
- Output register states: EMPTY (VY=0) and FULL (VY=1).
- Load enable: LD = ~VY | RY.
- Grant logic (combinational):
  - If V0 & V1: S1 = ~LAST (alternate).
  - Else if V1 only: S1 = 1.
  - Else: S1 = 0.
- Ready: R0 = LD & ~S1 & V0; R1 = LD & S1 & V1. At most one ready is high per cycle.
- Transfer on channel k: Vk & Rk at a rising edge. On that edge:
  - Y <= selected data (mux21 bank output).
  - VY <= 1.
  - LAST <= S1.
  - CNTk <= CNTk+1, wrapping modulo 2^CW (all-ones -> 0).
- Drain: VY & RY with no input transfer gives VY <= 0. Y holds its last value.
- Simultaneous drain and accept: VY stays 1 and Y takes the new word. This gives full throughput of one word per cycle.
- Hold: VY & ~RY means Y and VY are stable, R0=R1=0, and inputs are stalled.
- Latency: an input accepted at edge n appears on Y/VY after edge n; minimum 1 cycle.
- LAST updates only on a transfer. An uncontested grant still updates LAST.
- No valid input: S1=0, R0=R1=0, and no state changes except the drain.
- Inputs are not required to hold Dk while Vk=1 and Rk=0. The block never samples Dk without Rk.
- Reset asserted mid-transfer: reset wins and the edge's transfer is lost. On release, the first acceptance occurs on the first CLK edge after RST falls.

Decomposition:
- Small shared package (or header) with:
  - default W and CW;
  - reset value of LAST (1);
  - the grant encoding constants SEL_CH0=0 and SEL_CH1=1.
- One sub-module: mux21, instantiated W times via generate, with S1 to every slice, D0[i], D1[i], and output to the load mux of Y.
- Arbiter and output register stay in rr_merge2.

Test Plan:
1. Reset behaviour: RST=1 mid-run with VY=1 and Y=8'hA5 -> Y=0, VY=0, CNT0=CNT1=0 immediately, without waiting for a CLK edge. After release, V0=V1=1 with D0=8'h11, D1=8'h22 -> first output 8'h11 (S1=0).
2. Alternation: V0=V1=1 held, RY=1, 6 cycles, D0=8'h11, D1=8'h22 -> Y sequence 11,22,11,22,11,22; VY stays 1; CNT0=3, CNT1=3.
3. Back-pressure: VY=1, Y=8'h22, RY=0 for 4 cycles with both valid -> Y stays 8'h22, R0=R1=0. On RY=1 -> next Y=8'h11 the same edge, no bubble.
4. Single channel: only V1=1, 5 transfers with RY=1 -> S1=1 throughout, Y=D1 each cycle. Then V0=V1=1 -> channel 0 granted next (LAST=1).
5. Counter wrap: CW=8, 256 channel-0 transfers -> CNT0 returns to 0 and CNT1 stays 0.
6. Drain: single word accepted, then V0=V1=0 with RY=1 -> VY drops after one cycle and Y holds its value.
